alu_bist_sequencer: RTL and testbench

Synthesizable built-in self-test driver and response compactor for the 4-bit 181-style ALU. On `start` it applies the fixed operand pair against all 64 combinations of `{ci_n, m, s}`. It compresses each ALU response into a 16-bit MISR signature and reports completion. It sits beside the ALU in place of the simulation stimulus, so the ALU can be exercised in silicon or FPGA.

---
 rtl/alu_bist_pkg.sv | 17 +
 rtl/alu_bist_misr.sv | 30 +++
 rtl/alu_bist_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_bist_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the 181-style ALU BIST sequencer.
package alu_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  localparam int          VEC_COUNT = 64;
  localparam int          RESP_W    = 8;

endpackage

// File: rtl/alu_bist_misr.sv
// 16-bit MISR with seed load, enable and 8-bit parallel response input.
module alu_bist_misr
  import alu_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              seed,
  input  logic              en,
  input  logic [RESP_W-1:0] data,
  output logic [15:0]       sig,
  output logic [15:0]       sig_next
);

  always_comb begin
    sig_next = {sig[14:0], 1'b0}
             ^ (sig[15] ? MISR_POLY : 16'h0000)
             ^ {{(16-RESP_W){1'b0}}, data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= 16'h0000;
    end else if (seed) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/alu_bist_sequencer.sv
// BIST driver/compactor for a 4-bit 181-style ALU.
// Optional final-signature compare: define ALU_BIST_COMPARE_EN.
module alu_bist_sequencer
  import alu_bist_pkg::*;
#(
  parameter logic [3:0]  A_OPERAND     = 4'b0110,
  parameter logic [3:0]  B_OPERAND     = 4'b1011,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [3:0]  a_out,
  output logic [3:0]  b_out,
  output logic [3:0]  s_out,
  output logic        m_out,
  output logic        ci_n_out,
  input  logic [3:0]  y_in,
  input  logic        p_in,
  input  logic        q_in,
  input  logic        co_n_in,
  input  logic        aeqb_in
);

  state_t      state;
  logic [5:0]  idx;
  logic [3:0]  cnt;
  logic        seed;
  logic        cap;
  logic        cmp;
  logic [15:0] sig_next;
  logic [RESP_W-1:0] resp;

  assign seed = start && (state == S_IDLE || state == S_DONE);
  assign cap  = (state == S_CAPTURE);
  assign resp = {y_in, p_in, q_in, co_n_in, aeqb_in};

  alu_bist_misr u_misr (
    .clk      (clk),
    .rst      (rst),
    .seed     (seed),
    .en       (cap),
    .data     (resp),
    .sig      (signature),
    .sig_next (sig_next)
  );

`ifdef ALU_BIST_COMPARE_EN
  // Compare the post-fold value so pass lands on the same edge as done.
  assign cmp = (sig_next == GOLDEN_SIG);
`else
  logic unused_ok;
  assign unused_ok = ^{GOLDEN_SIG, sig_next};
  assign cmp = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= 6'd0;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      a_out    <= 4'd0;
      b_out    <= 4'd0;
      s_out    <= 4'd0;
      m_out    <= 1'b0;
      ci_n_out <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_APPLY;
            idx   <= 6'd0;
            cnt   <= 4'd0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
            a_out <= A_OPERAND;
            b_out <= B_OPERAND;
            {ci_n_out, m_out, s_out} <= 6'd0;
          end
        end
        S_APPLY: begin
          state <= S_SETTLE;
          cnt   <= 4'd0;
        end
        S_SETTLE: begin
          if (cnt == 4'(SETTLE_CYCLES - 1)) begin
            state <= S_CAPTURE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          if (idx == 6'(VEC_COUNT - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= cmp;
            a_out <= 4'd0;
            b_out <= 4'd0;
            {ci_n_out, m_out, s_out} <= 6'd0;
          end else begin
            state <= S_APPLY;
            idx   <= idx + 6'd1;
            {ci_n_out, m_out, s_out} <= idx + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Self-checking bench: ALU stand-in, run-level reference model, per-cycle compare.
module tb_alu_bist_sequencer;

  localparam logic [3:0]  A_OP   = 4'b0110;
  localparam logic [3:0]  B_OP   = 4'b1011;
  localparam logic [15:0] GOLDEN = 16'h0000;
  localparam int          P      = 3;
  localparam int          T      = 64 * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start4 = 1'b0;
  logic fault = 1'b0;

  logic        busy, done, pass;
  logic [15:0] signature;
  logic [3:0]  a_out, b_out, s_out, y_in;
  logic        m_out, ci_n_out, p_in, q_in, co_n_in, aeqb_in;

  logic        busy4, done4, pass4;
  logic [15:0] sig4;
  logic [3:0]  a4, b4, s4, y4;
  logic        m4, ci4, p4, q4, co4, eq4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 181-style ALU stand-in: returns {y, p, q, co_n, aeqb}
  function automatic logic [7:0] alu_resp(
    input logic [3:0] a, input logic [3:0] b,
    input logic [3:0] s, input logic m, input logic ci_n);
    logic [3:0] x, w, f, lg;
    logic [4:0] sum, raw;
    case (s)
      4'd0:  begin x = a;      w = 4'h0;   lg = ~a;       end
      4'd1:  begin x = a | b;  w = 4'h0;   lg = ~(a | b); end
      4'd2:  begin x = a | ~b; w = 4'h0;   lg = ~a & b;   end
      4'd3:  begin x = 4'h0;   w = 4'hF;   lg = 4'h0;     end
      4'd4:  begin x = a;      w = a & ~b; lg = ~(a & b); end
      4'd5:  begin x = a | b;  w = a & ~b; lg = ~b;       end
      4'd6:  begin x = a;      w = ~b;     lg = a ^ b;    end
      4'd7:  begin x = a & ~b; w = 4'hF;   lg = a & ~b;   end
      4'd8:  begin x = a;      w = a & b;  lg = ~a | b;   end
      4'd9:  begin x = a;      w = b;      lg = ~(a ^ b); end
      4'd10: begin x = a | ~b; w = a & b;  lg = b;        end
      4'd11: begin x = a & b;  w = 4'hF;   lg = a & b;    end
      4'd12: begin x = a;      w = a;      lg = 4'hF;     end
      4'd13: begin x = a | b;  w = a;      lg = a | ~b;   end
      4'd14: begin x = a | ~b; w = a;      lg = a | b;    end
      default: begin x = a;    w = 4'hF;   lg = a;        end
    endcase
    sum = {1'b0, x} + {1'b0, w} + {4'd0, ~ci_n};
    raw = {1'b0, x} + {1'b0, w};
    f = m ? lg : sum[3:0];
    return {f, ~&(x | w), ~raw[4], ~sum[4], &f};
  endfunction

  function automatic logic [7:0] resp_of(input int v, input bit flt);
    logic [5:0] iv;
    logic [7:0] r;
    iv = 6'(v);
    r = alu_resp(A_OP, B_OP, iv[3:0], iv[4], iv[5]);
    if (flt) r[4] = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] misr_step(
    input logic [15:0] sg, input logic [7:0] r);
    return (sg << 1) ^ (sg[15] ? 16'h1021 : 16'h0000) ^ {8'h00, r};
  endfunction

  function automatic logic [15:0] ref_sig(input bit flt);
    logic [15:0] sg = 16'hFFFF;
    for (int v = 0; v < 64; v++) sg = misr_step(sg, resp_of(v, flt));
    return sg;
  endfunction

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always_comb begin
    logic [7:0] r;
    r = alu_resp(a_out, b_out, s_out, m_out, ci_n_out);
    y_in = fault ? (r[7:4] & 4'b1110) : r[7:4];
    {p_in, q_in, co_n_in, aeqb_in} = r[3:0];
  end

  always_comb begin
    logic [7:0] r;
    r = alu_resp(a4, b4, s4, m4, ci4);
    {y4, p4, q4, co4, eq4} = r;
  end

  alu_bist_sequencer #(
    .A_OPERAND(A_OP), .B_OPERAND(B_OP),
    .SETTLE_CYCLES(1), .GOLDEN_SIG(GOLDEN)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .a_out(a_out), .b_out(b_out), .s_out(s_out),
    .m_out(m_out), .ci_n_out(ci_n_out),
    .y_in(y_in), .p_in(p_in), .q_in(q_in),
    .co_n_in(co_n_in), .aeqb_in(aeqb_in)
  );

  alu_bist_sequencer #(
    .A_OPERAND(A_OP), .B_OPERAND(B_OP),
    .SETTLE_CYCLES(4), .GOLDEN_SIG(GOLDEN)
  ) u_dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .busy(busy4), .done(done4), .pass(pass4), .signature(sig4),
    .a_out(a4), .b_out(b4), .s_out(s4),
    .m_out(m4), .ci_n_out(ci4),
    .y_in(y4), .p_in(p4), .q_in(q4),
    .co_n_in(co4), .aeqb_in(eq4)
  );

  // Run-level model: edges elapsed since the start edge
  bit          mrun = 1'b0;
  bit          mdone = 1'b0;
  int          mk = 0;
  logic [15:0] msig = 16'h0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mrun = 1'b0; mdone = 1'b0; mk = 0; msig = 16'h0000;
    end else if (!mrun && start) begin
      mrun = 1'b1; mdone = 1'b0; mk = 0; msig = 16'hFFFF;
    end else if (mrun) begin
      mk++;
      if (mk % P == 0) msig = misr_step(msig, resp_of(mk / P - 1, fault));
      if (mk == T) begin
        mrun = 1'b0; mdone = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] v;
    logic       ep;
    v = mrun ? 6'(mk / P) : 6'd0;
`ifdef ALU_BIST_COMPARE_EN
    ep = mdone && (msig == GOLDEN);
`else
    ep = 1'b0;
`endif
    check("busy", 16'(busy), 16'(mrun));
    check("done", 16'(done), 16'(mdone));
    check("pass", 16'(pass), 16'(ep));
    check("signature", signature, msig);
    check("a_out", 16'(a_out), mrun ? 16'(A_OP) : 16'd0);
    check("b_out", 16'(b_out), mrun ? 16'(B_OP) : 16'd0);
    check("vector", 16'({ci_n_out, m_out, s_out}), 16'(v));
  end

  task automatic run(input int abort_at, output logic [15:0] fsig);
    fsig = 16'hxxxx;
    @(negedge clk) start = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start = 1'b0;
        check("vec0", 16'({a_out, b_out, ci_n_out, m_out, s_out}),
              16'({A_OP, B_OP, 6'd0}));
      end
      if (n == 3) begin
        check("vec1_s", 16'(s_out), 16'd1);
        if (!fault) check("first_fold", signature, 16'hEFA1);
      end
      if (n == 48) check("vec16", 16'({ci_n_out, m_out, s_out}), 16'h10);
      if (n == 96) check("vec32", 16'({ci_n_out, m_out, s_out}), 16'h20);
      if (n == 50) start = 1'b1;
      if (n == 51) start = 1'b0;
      if (n == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_sig", signature, 16'h0000);
        check("abort_drv", 16'({a_out, b_out, ci_n_out, m_out, s_out}), 16'd0);
        @(negedge clk) rst = 1'b0;
        return;
      end
      if (n == T - 1) check("busy_before", 16'({busy, done}), 16'b10);
      if (n == T) begin
        check("done_at_192", 16'({busy, done}), 16'b01);
        fsig = signature;
        return;
      end
    end
  endtask

  initial begin
    logic [15:0] ref0, ref1, fs;
    int n4;
    check("pin_alu_v9", 16'(alu_resp(A_OP, B_OP, 4'd9, 1'b0, 1'b0)), 16'h20);
    check("pin_alu_v0", 16'(alu_resp(A_OP, B_OP, 4'd0, 1'b0, 1'b0)), 16'h7E);
    check("pin_misr", misr_step(16'hFFFF, 8'h7E), 16'hEFA1);
    ref0 = ref_sig(1'b0);
    ref1 = ref_sig(1'b1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_sig", signature, 16'h0000);
    check("idle_flags", 16'({busy, done, pass}), 16'd0);

    run(-1, fs);
    check("final_sig", fs, ref0);
    repeat (5) @(negedge clk);
    check("done_held", 16'({done, signature}), 16'({1'b1, ref0}));

    fault = 1'b1;
    run(-1, fs);
    check("fault_differs", 16'(fs != ref0), 16'd1);
    check("fault_sig", fs, ref1);
    check("fault_pass", 16'(pass), 16'd0);
    @(negedge clk) fault = 1'b0;

    run(100, fs);
    check("post_abort_state", 16'({busy, done, signature}), 16'd0);
    run(-1, fs);
    check("after_abort_sig", fs, ref0);

    @(negedge clk) start4 = 1'b1;
    n4 = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (n == 0) start4 = 1'b0;
      if (done4) begin
        n4 = n;
        break;
      end
    end
    check("settle4_edges", 16'(n4), 16'd384);
    check("settle4_sig", sig4, ref0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
